// File: rtl/bp_reg_arb.sv
// bp_reg_arb: two-requester round-robin arbiter in front of a shared bytepipe register memory
// Ports:
//   i_clk, i_rst_n (async active-low), i_cg (clock gate, 1 = enabled)
//   requester A/B: i_x_bp_* command in, o_x_bp_* response out (x = a, b)
//   memory: o_m_bp_* command out, i_m_bp_* response in
//   o_owner (00 none, 01 A, 10 B), o_timeout (one-cycle abort pulse)
module bp_reg_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cg,
    input  logic [7:0] i_a_bp_data,
    input  logic       i_a_bp_valid,
    output logic       o_a_bp_ready,
    output logic [7:0] o_a_bp_data,
    output logic       o_a_bp_valid,
    input  logic       i_a_bp_ready,
    input  logic [7:0] i_b_bp_data,
    input  logic       i_b_bp_valid,
    output logic       o_b_bp_ready,
    output logic [7:0] o_b_bp_data,
    output logic       o_b_bp_valid,
    input  logic       i_b_bp_ready,
    output logic [7:0] o_m_bp_data,
    output logic       o_m_bp_valid,
    input  logic       i_m_bp_ready,
    input  logic [7:0] i_m_bp_data,
    input  logic       i_m_bp_valid,
    output logic       o_m_bp_ready,
    output logic [1:0] o_owner,
    output logic       o_timeout
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;
    state_t      r_state, w_state_nx;
    logic [1:0]  r_owner, w_owner_nx;
    logic        r_last_a, w_last_a_nx;
    logic [15:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic        r_timeout, w_timeout_nx;
    logic        w_sel_a, w_cmd, w_resp, w_cmd_hs, w_rsp_hs;
    assign w_sel_a      = r_owner == 2'b01;
    assign w_cmd        = i_cg && (r_state == CMD || r_state == DATA);
    assign w_resp       = i_cg && r_state == RESP;
    assign o_m_bp_valid = w_cmd && (w_sel_a ? i_a_bp_valid : i_b_bp_valid);
    assign o_m_bp_data  = o_m_bp_valid ? (w_sel_a ? i_a_bp_data : i_b_bp_data) : 8'h00;
    assign o_a_bp_ready = w_cmd && w_sel_a && i_m_bp_ready;
    assign o_b_bp_ready = w_cmd && !w_sel_a && i_m_bp_ready;
    assign o_m_bp_ready = w_resp && (w_sel_a ? i_a_bp_ready : i_b_bp_ready);
    assign o_a_bp_valid = w_resp && w_sel_a && i_m_bp_valid;
    assign o_b_bp_valid = w_resp && !w_sel_a && i_m_bp_valid;
    assign o_a_bp_data  = o_a_bp_valid ? i_m_bp_data : 8'h00;
    assign o_b_bp_data  = o_b_bp_valid ? i_m_bp_data : 8'h00;
    assign w_cmd_hs     = o_m_bp_valid && i_m_bp_ready;
    assign w_rsp_hs     = i_m_bp_valid && o_m_bp_ready;
    assign w_cnt_inc    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign o_owner      = (r_state == IDLE) ? 2'b00 : r_owner;
    assign o_timeout    = r_timeout;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 2'b00;
            r_last_a  <= 1'b0;
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_owner   <= w_owner_nx;
            r_last_a  <= w_last_a_nx;
            r_cnt     <= w_cnt_nx;
            r_timeout <= w_timeout_nx;
        end
    end
    always_comb begin
        w_state_nx   = r_state;
        w_owner_nx   = r_owner;
        w_last_a_nx  = r_last_a;
        w_cnt_nx     = r_cnt;
        w_timeout_nx = 1'b0;
        if (i_cg) begin
            case (r_state)
                IDLE: if (i_a_bp_valid || i_b_bp_valid) begin
                    // B wins only when alone or when A was served most recently
                    w_owner_nx = (i_b_bp_valid && (!i_a_bp_valid || r_last_a)) ? 2'b10 : 2'b01;
                    w_state_nx = CMD;
                end
                CMD: if (w_cmd_hs) begin
                    w_state_nx = o_m_bp_data[7] ? DATA : RESP;
                    w_cnt_nx   = 16'd0;
                end
                DATA: if (w_cmd_hs) begin
                    w_state_nx = RESP;
                    w_cnt_nx   = 16'd0;
                end
                RESP: if (w_rsp_hs) begin
                    w_state_nx  = IDLE;
                    w_last_a_nx = w_sel_a;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                    if (TIMEOUT != 0 && w_cnt_inc >= 16'(TIMEOUT)) begin
                        w_state_nx   = IDLE;
                        w_last_a_nx  = w_sel_a;
                        w_timeout_nx = 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_reg_arb.sv
// tb_bp_reg_arb: directed self-checking bench for bp_reg_arb
module tb_bp_reg_arb;
    logic       i_clk = 1'b0;
    logic       i_rst_n, i_cg;
    logic [7:0] i_a_bp_data, i_b_bp_data, i_m_bp_data;
    logic       i_a_bp_valid, i_b_bp_valid, i_m_bp_valid;
    logic       i_a_bp_ready, i_b_bp_ready, i_m_bp_ready;
    logic [7:0] o_a_bp_data, o_b_bp_data, o_m_bp_data;
    logic       o_a_bp_valid, o_b_bp_valid, o_m_bp_valid;
    logic       o_a_bp_ready, o_b_bp_ready, o_m_bp_ready;
    logic [1:0] o_owner;
    logic       o_timeout;
    int checks = 0;
    int failures = 0;
    always #5 i_clk = ~i_clk;
    bp_reg_arb #(.TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg),
        .i_a_bp_data(i_a_bp_data), .i_a_bp_valid(i_a_bp_valid), .o_a_bp_ready(o_a_bp_ready),
        .o_a_bp_data(o_a_bp_data), .o_a_bp_valid(o_a_bp_valid), .i_a_bp_ready(i_a_bp_ready),
        .i_b_bp_data(i_b_bp_data), .i_b_bp_valid(i_b_bp_valid), .o_b_bp_ready(o_b_bp_ready),
        .o_b_bp_data(o_b_bp_data), .o_b_bp_valid(o_b_bp_valid), .i_b_bp_ready(i_b_bp_ready),
        .o_m_bp_data(o_m_bp_data), .o_m_bp_valid(o_m_bp_valid), .i_m_bp_ready(i_m_bp_ready),
        .i_m_bp_data(i_m_bp_data), .i_m_bp_valid(i_m_bp_valid), .o_m_bp_ready(o_m_bp_ready),
        .o_owner(o_owner), .o_timeout(o_timeout)
    );
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask
    logic [1:0] rr_exp [10] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    int pulses;
    initial begin
        i_rst_n = 1'b0; i_cg = 1'b1;
        i_a_bp_data = 8'h00; i_b_bp_data = 8'h00; i_m_bp_data = 8'h00;
        i_a_bp_valid = 1'b0; i_b_bp_valid = 1'b0; i_m_bp_valid = 1'b0;
        i_a_bp_ready = 1'b1; i_b_bp_ready = 1'b1; i_m_bp_ready = 1'b1;
        tick; tick;
        chk("rst_owner", 16'(o_owner), 16'h0);
        chk("rst_timeout", 16'(o_timeout), 16'h0);
        chk("rst_m_valid", 16'(o_m_bp_valid), 16'h0);
        chk("rst_m_ready", 16'(o_m_bp_ready), 16'h0);
        i_rst_n = 1'b1;
        // single read by A
        i_a_bp_valid = 1'b1; i_a_bp_data = 8'h05;
        #1;
        chk("idle_no_xfer", 16'(o_m_bp_valid), 16'h0);
        chk("idle_a_ready", 16'(o_a_bp_ready), 16'h0);
        tick;
        chk("rd_owner", 16'(o_owner), 16'h1);
        chk("rd_m_data", 16'(o_m_bp_data), 16'h05);
        chk("rd_a_ready", 16'(o_a_bp_ready), 16'h1);
        tick;
        i_a_bp_valid = 1'b0; i_m_bp_valid = 1'b1; i_m_bp_data = 8'h57;
        #1;
        chk("rd_resp_valid", 16'(o_a_bp_valid), 16'h1);
        chk("rd_resp_data", 16'(o_a_bp_data), 16'h57);
        chk("rd_m_ready", 16'(o_m_bp_ready), 16'h1);
        chk("rd_resp_m_valid", 16'(o_m_bp_valid), 16'h0);
        tick;
        i_m_bp_valid = 1'b0;
        chk("rd_done_owner", 16'(o_owner), 16'h0);
        // round robin from reset
        i_rst_n = 1'b0; tick; i_rst_n = 1'b1;
        i_a_bp_valid = 1'b1; i_a_bp_data = 8'h01;
        i_b_bp_valid = 1'b1; i_b_bp_data = 8'h02;
        i_m_bp_valid = 1'b1; i_m_bp_data = 8'h44;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("rr_owner%0d", i), 16'(o_owner), 16'(rr_exp[i]));
            if (rr_exp[i] == 2'b10) chk($sformatf("rr_a_ready%0d", i), 16'(o_a_bp_ready), 16'h0);
        end
        chk("rr_b_data", 16'(o_m_bp_data), 16'h02);
        tick;
        i_a_bp_valid = 1'b0; i_b_bp_valid = 1'b0;
        tick;
        i_m_bp_valid = 1'b0;
        chk("rr_done", 16'(o_owner), 16'h0);
        // write by B, A waits
        i_b_bp_valid = 1'b1; i_b_bp_data = 8'h83;
        tick;
        i_a_bp_valid = 1'b1; i_a_bp_data = 8'h11;
        #1;
        chk("wr_owner", 16'(o_owner), 16'h2);
        chk("wr_cmd", 16'(o_m_bp_data), 16'h83);
        chk("wr_b_ready", 16'(o_b_bp_ready), 16'h1);
        chk("wr_a_ready0", 16'(o_a_bp_ready), 16'h0);
        tick;
        i_b_bp_data = 8'hAA;
        #1;
        chk("wr_data", 16'(o_m_bp_data), 16'hAA);
        chk("wr_data_valid", 16'(o_m_bp_valid), 16'h1);
        chk("wr_a_ready1", 16'(o_a_bp_ready), 16'h0);
        tick;
        i_b_bp_valid = 1'b0; i_m_bp_valid = 1'b1; i_m_bp_data = 8'h3C;
        #1;
        chk("wr_resp_m_valid", 16'(o_m_bp_valid), 16'h0);
        chk("wr_resp_valid", 16'(o_b_bp_valid), 16'h1);
        chk("wr_resp_data", 16'(o_b_bp_data), 16'h3C);
        chk("wr_resp_a", 16'(o_a_bp_valid), 16'h0);
        chk("wr_a_ready2", 16'(o_a_bp_ready), 16'h0);
        tick;
        i_m_bp_valid = 1'b0;
        chk("wr_done", 16'(o_owner), 16'h0);
        // timeout on A, then B granted
        i_a_bp_data = 8'h07; i_b_bp_valid = 1'b1; i_b_bp_data = 8'h09;
        tick;
        chk("to_owner", 16'(o_owner), 16'h1);
        tick;
        i_a_bp_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            pulses += int'(o_timeout);
            chk($sformatf("to_wait%0d", i), 16'(o_owner), 16'h1);
        end
        tick;
        pulses += int'(o_timeout);
        chk("to_pulse", 16'(o_timeout), 16'h1);
        chk("to_idle", 16'(o_owner), 16'h0);
        tick;
        pulses += int'(o_timeout);
        chk("to_next_b", 16'(o_owner), 16'h2);
        chk("to_once", 16'(pulses), 16'h1);
        tick;
        i_b_bp_valid = 1'b0; i_m_bp_valid = 1'b1;
        tick;
        i_m_bp_valid = 1'b0;
        chk("to_b_done", 16'(o_owner), 16'h0);
        // clock gate during DATA
        i_a_bp_valid = 1'b1; i_a_bp_data = 8'h81;
        tick; tick;
        i_a_bp_data = 8'h22; i_cg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("cg_m_valid%0d", i), 16'(o_m_bp_valid), 16'h0);
            chk($sformatf("cg_a_ready%0d", i), 16'(o_a_bp_ready), 16'h0);
            chk($sformatf("cg_owner%0d", i), 16'(o_owner), 16'h1);
            tick;
        end
        i_cg = 1'b1;
        #1;
        chk("cg_data_valid", 16'(o_m_bp_valid), 16'h1);
        chk("cg_data", 16'(o_m_bp_data), 16'h22);
        tick;
        i_a_bp_valid = 1'b0; i_m_bp_valid = 1'b1; i_m_bp_data = 8'h5A;
        #1;
        chk("cg_resp", 16'(o_a_bp_data), 16'h5A);
        tick;
        i_m_bp_valid = 1'b0;
        chk("cg_done", 16'(o_owner), 16'h0);
        // async reset in RESP
        i_b_bp_valid = 1'b1; i_b_bp_data = 8'h04;
        tick; tick;
        i_b_bp_valid = 1'b0;
        chk("ar_m_ready_pre", 16'(o_m_bp_ready), 16'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar_owner", 16'(o_owner), 16'h0);
        chk("ar_m_ready", 16'(o_m_bp_ready), 16'h0);
        i_m_bp_valid = 1'b1; i_m_bp_data = 8'h99;
        #1;
        chk("ar_late_ready", 16'(o_m_bp_ready), 16'h0);
        chk("ar_late_valid", 16'(o_b_bp_valid), 16'h0);
        tick;
        chk("ar_held", 16'(o_m_bp_ready), 16'h0);
        i_m_bp_valid = 1'b0; i_rst_n = 1'b1; i_a_bp_valid = 1'b1; i_a_bp_data = 8'h01;
        tick;
        chk("ar_first_grant", 16'(o_owner), 16'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
